bcd_clock_core: RTL and testbench

Parametrised BCD time-of-day counter with an integrated prescaler. It keeps hours, minutes and seconds from a fast system clock and supports 12/24-hour display, a validated time-set (load) port, and per-unit rollover strobes. It sits between the board clock and the seven-segment/display driver. It extends the plain binary sec/min/hour counter with BCD digits, loadability, enable and event outputs.

---
 rtl/bcd_clock_core_pkg.sv | 60 ++++++
 rtl/bcd_clock_core_if.sv | 33 +++
 rtl/bcd_mod_counter.sv | 38 +++
 rtl/bcd_clock_core.sv | 87 ++++++++
 tb/tb_bcd_clock_core.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/bcd_clock_core_pkg.sv
// Shared types and BCD helpers for the time-of-day counter.
package bcd_clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_59 = 8'h59;
  localparam bcd2_t BCD_23 = 8'h23;

  typedef struct packed {
    bcd2_t val;
    logic  wrap;
  } bcd2_inc_t;

  typedef struct packed {
    bcd2_t hour;
    logic  pm;
  } hour12_t;

  // Both nibbles decimal and the pair no larger than max.
  // Valid BCD orders the same way as plain binary.
  function automatic logic bcd2_valid(bcd2_t value, bcd2_t max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

  // BCD increment of a digit pair. wrap flags the 99 -> 00 overflow.
  function automatic bcd2_inc_t bcd2_inc(bcd2_t value);
    bcd2_inc_t r;
    r.wrap = 1'b0;
    r.val  = value;
    if (value[3:0] == 4'd9) begin
      r.val[3:0] = 4'd0;
      if (value[7:4] == 4'd9) begin
        r.val[7:4] = 4'd0;
        r.wrap     = 1'b1;
      end else begin
        r.val[7:4] = value[7:4] + 4'd1;
      end
    end else begin
      r.val[3:0] = value[3:0] + 4'd1;
    end
    return r;
  endfunction

  // 24-hour BCD hours to the 12-hour display form plus pm flag.
  function automatic hour12_t to_12h(bcd2_t hh);
    hour12_t    r;
    logic [6:0] b;
    logic [6:0] b12;
    b      = 7'(hh[7:4]) * 7'd10 + 7'(hh[3:0]);
    b12    = b - 7'd12;
    r.pm   = (b >= 7'd12);
    r.hour = hh;
    if (b == 7'd0)
      r.hour = 8'h12;
    else if (b > 7'd12)
      r.hour = {4'(b12 / 7'd10), 4'(b12 % 7'd10)};
    return r;
  endfunction

endpackage

// File: rtl/bcd_clock_core_if.sv
// Control, load and display signals between the clock core and its user.
interface bcd_clock_core_if;
  import bcd_clock_pkg::*;

  logic  en;
  logic  mode_12h;
  logic  load;
  bcd2_t load_hh;
  bcd2_t load_mm;
  bcd2_t load_ss;
  bcd2_t sec_bcd;
  bcd2_t min_bcd;
  bcd2_t hour_bcd;
  logic  pm;
  logic  sec_tick;
  logic  min_tick;
  logic  hour_tick;
  logic  day_tick;
  logic  load_err;

  modport master (
    output en, mode_12h, load, load_hh, load_mm, load_ss,
    input  sec_bcd, min_bcd, hour_bcd, pm,
    input  sec_tick, min_tick, hour_tick, day_tick, load_err
  );

  modport slave (
    input  en, mode_12h, load, load_hh, load_mm, load_ss,
    output sec_bcd, min_bcd, hour_bcd, pm,
    output sec_tick, min_tick, hour_tick, day_tick, load_err
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX; wrap_o is the carry into the next unit.
module bcd_mod_counter
  import bcd_clock_pkg::*;
#(
  parameter bcd2_t MAX = BCD_59
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  inc_i,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  output bcd2_t value_o,
  output logic  wrap_o
);

  bcd2_t value_q, value_d;
  logic  at_max;

  assign at_max  = (value_q == MAX);
  assign wrap_o  = inc_i & at_max;
  assign value_o = value_q;

  // Load wins over increment; wrap to zero at MAX.
  always_comb begin
    value_d = value_q;
    if (load_i)
      value_d = load_val_i;
    else if (inc_i)
      value_d = at_max ? '0 : bcd2_inc(value_q).val;
  end

  // Digit pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/bcd_clock_core.sv
// BCD time-of-day clock: prescaler, validated load, chained digit counters, strobes.
module bcd_clock_core
  import bcd_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PRESCALE_W    = $clog2(TICKS_PER_SEC)
) (
  input  logic              clk,
  input  logic              rst_n,
  bcd_clock_core_if.slave   bus
);

  localparam logic [PRESCALE_W-1:0] PS_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic  load_valid, load_ok, sec_adv;
  logic  ss_wrap, mm_wrap, hh_wrap;
  bcd2_t ss, mm, hh;
  logic  sec_tick_q, min_tick_q, hour_tick_q, day_tick_q, load_err_q;
  hour12_t h12;

  assign load_valid = bcd2_valid(bus.load_ss, BCD_59) &
                      bcd2_valid(bus.load_mm, BCD_59) &
                      bcd2_valid(bus.load_hh, BCD_23);
  assign load_ok    = bus.load & load_valid;
  // A rejected load does not disturb counting on that edge.
  assign sec_adv    = bus.en & ~load_ok & (presc_q == PS_LAST);

  // Prescaler: cleared by an accepted load, frozen while disabled.
  always_comb begin
    presc_d = presc_q;
    if (load_ok)
      presc_d = '0;
    else if (bus.en)
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PRESCALE_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  bcd_mod_counter #(.MAX(BCD_59)) u_ss (
    .clk(clk), .rst_n(rst_n), .inc_i(sec_adv), .load_i(load_ok),
    .load_val_i(bus.load_ss), .value_o(ss), .wrap_o(ss_wrap)
  );

  bcd_mod_counter #(.MAX(BCD_59)) u_mm (
    .clk(clk), .rst_n(rst_n), .inc_i(ss_wrap), .load_i(load_ok),
    .load_val_i(bus.load_mm), .value_o(mm), .wrap_o(mm_wrap)
  );

  bcd_mod_counter #(.MAX(BCD_23)) u_hh (
    .clk(clk), .rst_n(rst_n), .inc_i(mm_wrap), .load_i(load_ok),
    .load_val_i(bus.load_hh), .value_o(hh), .wrap_o(hh_wrap)
  );

  // Strobes line up with the first cycle the new time is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sec_tick_q  <= sec_adv;
      min_tick_q  <= ss_wrap;
      hour_tick_q <= mm_wrap;
      day_tick_q  <= hh_wrap;
      load_err_q  <= bus.load & ~load_valid;
    end
  end

  assign h12          = to_12h(hh);
  assign bus.sec_bcd  = ss;
  assign bus.min_bcd  = mm;
  assign bus.hour_bcd = bus.mode_12h ? h12.hour : hh;
  assign bus.pm       = h12.pm;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.min_tick  = min_tick_q;
  assign bus.hour_tick = hour_tick_q;
  assign bus.day_tick  = day_tick_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_clock_core.sv
// Directed bench for bcd_clock_core with TICKS_PER_SEC = 4.
module tb_bcd_clock_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  bcd_clock_core_if bus ();

  bcd_clock_core #(.TICKS_PER_SEC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling / driving.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, "_time"}, {8'h0, bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, {8'h0, h, m, s});
  endtask

  // Ticks packed as {day, hour, min, sec}.
  task automatic check_ticks(input string tag, input logic [3:0] exp);
    check({tag, "_ticks"}, {28'h0, bus.day_tick, bus.hour_tick, bus.min_tick, bus.sec_tick},
          {28'h0, exp});
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.load = 1'b1; bus.load_hh = h; bus.load_mm = m; bus.load_ss = s;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.mode_12h = 1'b0; bus.load = 1'b0;
    bus.load_hh = 8'h00; bus.load_mm = 8'h00; bus.load_ss = 8'h00;

    // Reset state
    step(2);
    check_time("rst24", 8'h00, 8'h00, 8'h00);
    check("rst_pm", {31'h0, bus.pm}, 32'h0);
    check_ticks("rst", 4'b0000);
    check("rst_err", {31'h0, bus.load_err}, 32'h0);
    bus.mode_12h = 1'b1; #1;
    check("rst12_hour", {24'h0, bus.hour_bcd}, 32'h12);
    bus.mode_12h = 1'b0;

    // First second after reset
    rst_n = 1'b1; bus.en = 1'b1;
    step(3);
    check("pre_sec", {24'h0, bus.sec_bcd}, 32'h00);
    check_ticks("pre_sec", 4'b0000);
    step();
    check("sec1", {24'h0, bus.sec_bcd}, 32'h01);
    check_ticks("sec1", 4'b0001);
    step();
    check_ticks("sec1_after", 4'b0000);
    step(31);                                 // edge 36
    check("sec9", {24'h0, bus.sec_bcd}, 32'h09);
    step(4);                                  // edge 40
    check("sec10", {24'h0, bus.sec_bcd}, 32'h10);
    check_ticks("sec10", 4'b0001);

    // Day wrap
    do_load(8'h23, 8'h59, 8'h58);
    check_time("ld235958", 8'h23, 8'h59, 8'h58);
    check_ticks("ld235958", 4'b0000);
    step(4);
    check_time("t235959", 8'h23, 8'h59, 8'h59);
    check_ticks("t235959", 4'b0001);
    step(4);
    check_time("t000000", 8'h00, 8'h00, 8'h00);
    check_ticks("daywrap", 4'b1111);
    step();
    check_ticks("daywrap_after", 4'b0000);

    // Rejected loads; counting carries on underneath
    do_load(8'h10, 8'h20, 8'h30);              // prescaler 0
    do_load(8'h24, 8'h00, 8'h00);              // prescaler 1
    check_time("rej_hh", 8'h10, 8'h20, 8'h30);
    check("rej_hh_err", {31'h0, bus.load_err}, 32'h1);
    step();                                    // prescaler 2
    check("rej_hh_err_end", {31'h0, bus.load_err}, 32'h0);
    do_load(8'h10, 8'h5A, 8'h00);              // prescaler 3
    check_time("rej_mm", 8'h10, 8'h20, 8'h30);
    check("rej_mm_err", {31'h0, bus.load_err}, 32'h1);
    step();                                    // tick
    check_time("rej_cont", 8'h10, 8'h20, 8'h31);
    check_ticks("rej_cont", 4'b0001);
    check("rej_mm_err_end", {31'h0, bus.load_err}, 32'h0);

    // Load coincident with a due tick
    step(3);                                   // prescaler 3, tick due next
    check("pre_ld_ss", {24'h0, bus.sec_bcd}, 32'h31);
    do_load(8'h01, 8'h02, 8'h03);
    check_time("ld_tick", 8'h01, 8'h02, 8'h03);
    check_ticks("ld_tick", 4'b0000);
    step(3);
    check("ld_restart3", {24'h0, bus.sec_bcd}, 32'h03);
    step();
    check("ld_restart4", {24'h0, bus.sec_bcd}, 32'h04);
    check_ticks("ld_restart4", 4'b0001);

    // 12-hour mapping (frozen so loads stay put)
    bus.en = 1'b0; bus.mode_12h = 1'b1;
    do_load(8'h00, 8'h00, 8'h00);
    check("h12_00", {23'h0, bus.hour_bcd, bus.pm}, {23'h0, 8'h12, 1'b0});
    do_load(8'h12, 8'h00, 8'h00);
    check("h12_12", {23'h0, bus.hour_bcd, bus.pm}, {23'h0, 8'h12, 1'b1});
    do_load(8'h13, 8'h00, 8'h00);
    check("h12_13", {23'h0, bus.hour_bcd, bus.pm}, {23'h0, 8'h01, 1'b1});
    bus.mode_12h = 1'b0; #1;
    check("h24_13", {23'h0, bus.hour_bcd, bus.pm}, {23'h0, 8'h13, 1'b1});
    bus.mode_12h = 1'b1;
    do_load(8'h23, 8'h00, 8'h00);
    check("h12_23", {23'h0, bus.hour_bcd, bus.pm}, {23'h0, 8'h11, 1'b1});
    do_load(8'h09, 8'h00, 8'h00);
    check("h12_09", {23'h0, bus.hour_bcd, bus.pm}, {23'h0, 8'h09, 1'b0});
    bus.mode_12h = 1'b0;

    // Enable hold mid-second, no phase reset
    do_load(8'h05, 8'h06, 8'h07);
    bus.en = 1'b1;
    step(2);                                   // prescaler 2
    bus.en = 1'b0;
    step(10);
    check_time("hold", 8'h05, 8'h06, 8'h07);
    check_ticks("hold", 4'b0000);
    bus.en = 1'b1;
    step();                                    // prescaler 3
    check("resume1", {24'h0, bus.sec_bcd}, 32'h07);
    step();
    check("resume2", {24'h0, bus.sec_bcd}, 32'h08);
    check_ticks("resume2", 4'b0001);

    // Asynchronous reset mid-count
    step(2);
    #2 rst_n = 1'b0;
    #1;
    check_time("arst", 8'h00, 8'h00, 8'h00);
    check("arst_pm", {31'h0, bus.pm}, 32'h0);
    check_ticks("arst", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
